// File: rtl/complete_buffer.sv
// complete_buffer: per-functional-unit result holding slots that feed a
// common data bus (CDB). Each slot captures one finished FU result, waits
// for the downstream selector to grant it, and is broadcast one cycle
// after the grant. A per-slot wait counter flags slots that sit unserved.
//
// Ports:
//   clock, reset     single clock, synchronous active-high reset
//   squash           mispredict flush: empties every slot, blocks capture
//   fu_done          per-FU "result presented this cycle"
//   fu_tag/fu_value  per-FU packed result tag and value
//   grant            selector grant; only the highest set bit is honoured
//   fu_ready         per-slot "can accept a result this cycle"
//   fu_result_valid  per-slot occupied flag (registered only)
//   cdb_valid/tag/value  registered broadcast, one cycle after grant
//   starve_alert     some slot's wait count has reached STARVE_LIMIT
module complete_buffer #(
  parameter int NUM_FU       = 8,
  parameter int TAG_W        = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_value,
  input  logic [NUM_FU-1:0]        grant,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        fu_result_valid,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic                     starve_alert
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NUM_FU-1:0]             valid_vec;
  logic [NUM_FU-1:0]             grant_top;
  logic [NUM_FU-1:0]             eff_grant;
  logic [NUM_FU-1:0]             capture;
  logic [NUM_FU-1:0]             at_limit;
  logic [NUM_FU-1:0][TAG_W-1:0]  slot_tag;
  logic [NUM_FU-1:0][DATA_W-1:0] slot_value;

  // Reduce grant to its highest set bit; the later loop iteration wins.
  always_comb begin
    grant_top = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        grant_top    = '0;
        grant_top[i] = 1'b1;
      end
    end
  end

  // A grant that lands on an empty slot is treated as no grant at all.
  assign eff_grant = grant_top & valid_vec;
  // fu_ready depends only on state, grant and squash, never on fu_done.
  assign fu_ready  = (~valid_vec | eff_grant) & {NUM_FU{~squash}};
  assign capture   = fu_done & fu_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
      logic              valid_q, valid_d;
      logic [3:0]        wait_q, wait_d;
      logic [TAG_W-1:0]  tag_q;
      logic [DATA_W-1:0] value_q;

      always_comb begin
        valid_d = valid_q;
        wait_d  = wait_q;
        if (squash) begin
          valid_d = 1'b0;
          wait_d  = 4'd0;
        end else if (capture[gi]) begin
          // Covers the grant-and-refill case: the new result starts fresh.
          valid_d = 1'b1;
          wait_d  = 4'd0;
        end else if (eff_grant[gi]) begin
          valid_d = 1'b0;
          wait_d  = 4'd0;
        end else if (valid_q) begin
          if (wait_q != LIMIT) wait_d = wait_q + 4'd1;
        end else begin
          wait_d = 4'd0;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_q <= 1'b0;
          wait_q  <= 4'd0;
        end else begin
          valid_q <= valid_d;
          wait_q  <= wait_d;
        end
      end

      // Payload needs no reset; it is only observed while valid_q is set.
      always_ff @(posedge clock) begin
        if (!reset && capture[gi]) begin
          tag_q   <= fu_tag[gi*TAG_W +: TAG_W];
          value_q <= fu_value[gi*DATA_W +: DATA_W];
        end
      end

      assign valid_vec[gi]       = valid_q;
      assign fu_result_valid[gi] = valid_q;
      assign at_limit[gi]        = (wait_q == LIMIT);
      assign slot_tag[gi]        = tag_q;
      assign slot_value[gi]      = value_q;
    end
  endgenerate

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

  // eff_grant is one-hot or zero, so a plain priority loop is a clean mux.
  always_comb begin
    cdb_valid_d = (|eff_grant) & ~squash;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (eff_grant[i] && !squash) begin
        cdb_tag_d   = slot_tag[i];
        cdb_value_d = slot_value[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_value    = cdb_value_q;
  assign starve_alert = |at_limit;

endmodule

// File: tb/tb_complete_buffer.sv
// tb_complete_buffer: directed scenarios followed by random traffic, all
// checked against a slot-level behavioural model of the buffer.
module tb_complete_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [7:0]  fu_done;
  logic [39:0] fu_tag;
  logic [255:0] fu_value;
  logic [7:0]  grant;
  logic [7:0]  fu_ready;
  logic [7:0]  fu_result_valid;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        starve_alert;

  logic [4:0]  d_tag [8];
  logic [31:0] d_val [8];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_valid [8];
  logic [4:0]  m_tag   [8];
  logic [31:0] m_val   [8];
  int          m_wait  [8];
  bit          m_cdbv;
  logic [4:0]  m_cdbt;
  logic [31:0] m_cdbd;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      fu_tag[i*5 +: 5]    = d_tag[i];
      fu_value[i*32 +: 32] = d_val[i];
    end
  end

  complete_buffer dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done(fu_done), .fu_tag(fu_tag), .fu_value(fu_value),
    .grant(grant), .fu_ready(fu_ready), .fu_result_valid(fu_result_valid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .starve_alert(starve_alert)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input int i, input logic [4:0] t, input logic [31:0] v);
    d_tag[i] = t;
    d_val[i] = v;
  endtask

  // One clock of stimulus: drive, check fu_ready, advance model, check outputs.
  task automatic step(input logic [7:0] done, input logic [7:0] gnt,
                      input logic sq, input logic rst);
    int hi, eg;
    logic [7:0] exp_ready, exp_rv;
    bit any_starve;
    @(negedge clock);
    fu_done = done; grant = gnt; squash = sq; reset = rst;
    #1;
    hi = -1;
    for (int i = 7; i >= 0; i--) if (gnt[i] && hi < 0) hi = i;
    eg = (hi >= 0 && m_valid[hi]) ? hi : -1;
    for (int i = 0; i < 8; i++) exp_ready[i] = (!m_valid[i] || i == eg) && !sq;
    check("fu_ready", 64'(fu_ready), 64'(exp_ready));

    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_wait[i] = 0; end
      m_cdbv = 0; m_cdbt = '0; m_cdbd = '0;
    end else if (sq) begin
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_wait[i] = 0; end
      m_cdbv = 0;
    end else begin
      m_cdbv = (eg >= 0);
      if (eg >= 0) begin m_cdbt = m_tag[eg]; m_cdbd = m_val[eg]; end
      for (int i = 0; i < 8; i++) begin
        if (done[i] && exp_ready[i]) begin
          m_valid[i] = 1; m_tag[i] = d_tag[i]; m_val[i] = d_val[i]; m_wait[i] = 0;
        end else if (i == eg) begin
          m_valid[i] = 0; m_wait[i] = 0;
        end else if (m_valid[i]) begin
          if (m_wait[i] < 15) m_wait[i]++;
        end else begin
          m_wait[i] = 0;
        end
      end
    end

    @(posedge clock);
    #1;
    any_starve = 0;
    for (int i = 0; i < 8; i++) begin
      exp_rv[i] = m_valid[i];
      if (m_wait[i] == 15) any_starve = 1;
    end
    check("fu_result_valid", 64'(fu_result_valid), 64'(exp_rv));
    check("cdb_valid", 64'(cdb_valid), 64'(m_cdbv));
    check("cdb_tag", 64'(cdb_tag), 64'(m_cdbt));
    check("cdb_value", 64'(cdb_value), 64'(m_cdbd));
    check("starve_alert", 64'(starve_alert), 64'(any_starve));
    $display("step done=%h grant=%h squash=%b reset=%b -> rv=%h cdb=%b/%h/%h starve=%b",
             done, gnt, sq, rst, fu_result_valid, cdb_valid, cdb_tag, cdb_value, starve_alert);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_wait[i] = 0; m_tag[i] = '0; m_val[i] = '0;
      set_res(i, 5'(i), 32'h1000 + 32'(i));
    end
    m_cdbv = 0; m_cdbt = '0; m_cdbd = '0;
    reset = 1'b1; squash = 1'b0; fu_done = '0; grant = '0;
    repeat (2) @(posedge clock);

    // Reset state, then fu_ready all-ones on first free cycle
    step(8'h00, 8'h00, 1'b0, 1'b1);
    check("reset_cdb_tag_zero", 64'(cdb_tag), 64'd0);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // Single capture and broadcast from slot 0
    set_res(0, 5'd3, 32'hDEAD_BEEF);
    step(8'h01, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h01, 1'b0, 1'b0);
    check("bcast_tag3", 64'(cdb_tag), 64'd3);
    check("bcast_deadbeef", 64'(cdb_value), 64'hDEAD_BEEF);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // Grant slot 2 while it is refilled in the same cycle
    set_res(2, 5'd9, 32'h0000_0909);
    step(8'h04, 8'h00, 1'b0, 1'b0);
    set_res(2, 5'd7, 32'h0000_0707);
    step(8'h04, 8'h04, 1'b0, 1'b0);
    check("refill_old_tag", 64'(cdb_tag), 64'd9);
    step(8'h00, 8'h04, 1'b0, 1'b0);
    check("refill_new_tag", 64'(cdb_tag), 64'd7);

    // Multi-bit grant honours only the highest bit
    set_res(1, 5'd11, 32'h1111_1111);
    set_res(6, 5'd16, 32'h6666_6666);
    step(8'h42, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h42, 1'b0, 1'b0);
    check("multi_grant_slot6", 64'(cdb_tag), 64'd16);
    step(8'h00, 8'h02, 1'b0, 1'b0);

    // Starvation: slot 4 left alone, then granted
    set_res(4, 5'd20, 32'h4444_4444);
    step(8'h10, 8'h00, 1'b0, 1'b0);
    repeat (17) step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h10, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // Squash beats grant and capture
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    step(8'hFF, 8'h80, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation with a pending grant
    step(8'h07, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h04, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] gnt;
      for (int i = 0; i < 8; i++) set_res(i, 5'($urandom), $urandom);
      gnt = ($urandom % 2) ? 8'(1 << ($urandom % 8)) : 8'($urandom);
      if ($urandom % 4 == 0) gnt = 8'h00;
      step(8'($urandom & $urandom), gnt, ($urandom % 20) == 0, ($urandom % 60) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
